// File: rtl/vend_output_ctrl.sv
// vend_output_ctrl: turns dispense/change rising edges from the vending
// controller into an ordered queue of actuator jobs. Jobs run one at a time:
// the vend motor for an item, the coin ejector for one quarter. Each job is
// held until its sensor acknowledges it. A missing acknowledge latches a
// sticky fault, and a request dropped on a full queue latches a sticky overflow.
module vend_output_ctrl #(
    parameter int DEPTH          = 8,
    parameter int MOTOR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dispense,
    input  logic                     change,
    input  logic                     item_sensed,
    input  logic                     coin_sensed,
    output logic                     vend_motor,
    output logic                     coin_eject,
    output logic                     vend_done,
    output logic                     change_done,
    output logic                     busy,
    output logic                     fault,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, FAULT} state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic            typ, typ_n;        // 0 = vend job, 1 = change job
    logic            done_v_n, done_c_n;

    logic            dispense_q, change_q;
    logic            vend_req, chg_req;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]   wptr, rptr, wptr_inc;
    logic [CW-1:0]   count;
    logic [CW:0]     free, need_chg;
    logic            pop, push_vend, push_chg, drop, head, ack;

    assign vend_req = dispense & ~dispense_q;
    assign chg_req  = change & ~change_q;
    assign wptr_inc = wptr + AW'(1);
    assign head     = mem[rptr];

    // The FSM takes at most one job per clock, and only from IDLE.
    assign pop = (state == IDLE) && (count != '0);

    // A slot freed by a pop in this clock can be refilled in the same clock.
    // A vend is queued ahead of a change, so a change that arrives with a vend
    // needs two free slots.
    always_comb begin
        free      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        need_chg  = vend_req ? (CW+1)'(2) : (CW+1)'(1);
        push_vend = vend_req && (free >= (CW+1)'(1));
        push_chg  = chg_req && (free >= need_chg);
        drop      = (vend_req && !push_vend) || (chg_req && !push_chg);
    end

    // Edge-detect history and queue pointers/occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
        end else begin
            dispense_q <= dispense;
            change_q   <= change;
            wptr       <= wptr + AW'(push_vend) + AW'(push_chg);
            rptr       <= rptr + AW'(pop);
            count      <= count + CW'(push_vend) + CW'(push_chg) - CW'(pop);
        end
    end

    // Queue storage. Stale entries are never read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_vend) mem[wptr] <= 1'b0;
        if (push_chg)  mem[push_vend ? wptr_inc : wptr] <= 1'b1;
    end

    // Next-state logic. An acknowledge is checked before the timeout, so an
    // acknowledge on the last timeout clock still counts as done.
    always_comb begin
        state_n  = state;
        tmr_n    = tmr;
        typ_n    = typ;
        done_v_n = 1'b0;
        done_c_n = 1'b0;
        ack      = typ ? coin_sensed : item_sensed;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_n = DRIVE;
                    typ_n   = head;
                    tmr_n   = '0;
                end
            end
            DRIVE, WAIT: begin
                if (ack) begin
                    state_n  = IDLE;
                    done_v_n = ~typ;
                    done_c_n = typ;
                end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = FAULT;
                end else begin
                    tmr_n = tmr + TW'(1);
                    if ((state == DRIVE) && (tmr == TW'(MOTOR_CYCLES - 1)))
                        state_n = WAIT;
                end
            end
            default: state_n = FAULT;
        endcase
    end

    // State register. Actuator and flag outputs are registered from the next
    // state, so an actuator drops on the same clock that its acknowledge is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            typ         <= 1'b0;
            vend_motor  <= 1'b0;
            coin_eject  <= 1'b0;
            vend_done   <= 1'b0;
            change_done <= 1'b0;
            fault       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            typ         <= typ_n;
            vend_motor  <= (state_n == DRIVE) && !typ_n;
            coin_eject  <= (state_n == DRIVE) && typ_n;
            vend_done   <= done_v_n;
            change_done <= done_c_n;
            fault       <= (state_n == FAULT);
            overflow    <= overflow | drop;
        end
    end

    assign pending = count;
    assign busy    = (state != IDLE) || (count != '0);

endmodule
